// File: rtl/fifo_param.sv
// Parameterised single-clock FIFO with status flags, sticky error and selectable read mode.
// FWFT=0 registers the head word on a read; FWFT=1 presents the head word combinationally.
module fifo_param #(
  parameter int MEM_SIZE  = 8,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic [PTR_L:0]       full_threshold,
  input  logic [PTR_L:0]       empty_threshold,
  input  logic                 err_clear,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_valid,
  output logic [PTR_L:0]       fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 error
);

  localparam logic [PTR_L:0] DEPTH = (PTR_L+1)'(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [PTR_L-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_L:0]       count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 err_q, err_d;
  logic                 rd_acc, wr_acc;

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  assign rd_acc = fifo_rd && (count_q != '0);
  assign wr_acc = fifo_wr && ((count_q != DEPTH) || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = fifo_wr && !wr_acc;
    udf_d = fifo_rd && (count_q == '0);
    // A new violation outranks a same-cycle clear.
    if (ovf_d || udf_d)  err_d = 1'b1;
    else if (err_clear)  err_d = 1'b0;
    else                 err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= fifo_data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_data_out = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
      assign fifo_valid    = (count_q != '0);
    end else begin : g_reg
      logic [WORD_SIZE-1:0] dout_q, dout_d;
      logic                 vld_q;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          dout_q <= dout_d;
          vld_q  <= rd_acc;
        end
      end

      assign fifo_data_out = dout_q;
      assign fifo_valid    = vld_q;
    end
  endgenerate

  assign fifo_count   = count_q;
  assign fifo_full    = (count_q == DEPTH);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (full_threshold != '0) && (count_q >= full_threshold);
  assign almost_empty = (count_q <= empty_threshold);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign error        = err_q;

endmodule
